// File: rtl/matmul_ctrl_if.sv
// Host handshake and datapath control bundle for matmul_ctrl.
// master: host/testbench side; slave: the sequencer.
interface matmul_ctrl_if #(
    parameter int ROM_AW = 5,
    parameter int RAM_AW = 4
);
    logic              start;
    logic              valid_input;
    logic              input_load_en;
    logic              X_shift;
    logic [ROM_AW-1:0] rom_addr;
    logic              mac_en;
    logic              mac_clr;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [1:0]        wr_row;
    logic              busy;
    logic              done;

    modport master (
        output start, valid_input,
        input  input_load_en, X_shift, rom_addr, mac_en, mac_clr,
        input  ram_we, ram_addr, wr_row, busy, done
    );

    modport slave (
        input  start, valid_input,
        output input_load_en, X_shift, rom_addr, mac_en, mac_clr,
        output ram_we, ram_addr, wr_row, busy, done
    );
endinterface

// File: rtl/matmul_ctrl.sv
// Sequencer for the 4x8 x 8xCOLS matmul: LOAD 32 bytes, MAC 8/column, WRITE 4 rows/column.
// Ports: clk, rst (async active-low), bus (slave: start/valid in; X/ROM/MAC/RAM controls, busy, done out).
module matmul_ctrl #(
    parameter int COLS   = 4,
    parameter int ROM_AW = 5,
    parameter int RAM_AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    matmul_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [2:0] COL_LAST = 3'(COLS - 1);

    state_t     state, state_nx;
    logic [4:0] load_cnt, load_cnt_nx;
    logic [2:0] k, k_nx;
    logic [1:0] row, row_nx;
    logic [2:0] col, col_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            load_cnt <= '0;
            k        <= '0;
            row      <= '0;
            col      <= '0;
        end else begin
            state    <= state_nx;
            load_cnt <= load_cnt_nx;
            k        <= k_nx;
            row      <= row_nx;
            col      <= col_nx;
        end
    end

    always_comb begin
        state_nx          = state;
        load_cnt_nx       = load_cnt;
        k_nx              = k;
        row_nx            = row;
        col_nx            = col;
        bus.input_load_en = 1'b0;
        bus.X_shift       = 1'b0;
        bus.rom_addr      = '0;
        bus.mac_en        = 1'b0;
        bus.mac_clr       = 1'b0;
        bus.ram_we        = 1'b0;
        bus.ram_addr      = '0;
        bus.wr_row        = '0;
        bus.busy          = 1'b0;
        bus.done          = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx    = S_LOAD;
                    load_cnt_nx = '0;
                    k_nx        = '0;
                    row_nx      = '0;
                    col_nx      = '0;
                end
            end
            S_LOAD: begin
                bus.busy          = 1'b1;
                bus.input_load_en = 1'b1;
                if (bus.valid_input) begin
                    load_cnt_nx = load_cnt + 5'd1;
                    if (load_cnt == 5'd31) begin
                        state_nx = S_MAC;
                        k_nx     = '0;
                        col_nx   = '0;
                    end
                end
            end
            S_MAC: begin
                bus.busy     = 1'b1;
                bus.X_shift  = 1'b1;
                bus.mac_en   = 1'b1;
                bus.mac_clr  = (k == 3'd0);
                bus.rom_addr = ROM_AW'({col, k});
                k_nx         = k + 3'd1;
                // Eight rotations restore X, so the next column reuses it as-is.
                if (k == 3'd7) begin
                    state_nx = S_WRITE;
                    row_nx   = '0;
                end
            end
            S_WRITE: begin
                bus.busy     = 1'b1;
                bus.ram_we   = 1'b1;
                bus.wr_row   = row;
                bus.ram_addr = RAM_AW'({col, row});
                row_nx       = row + 2'd1;
                if (row == 2'd3) begin
                    if (col == COL_LAST) begin
                        state_nx = S_DONE;
                    end else begin
                        col_nx   = col + 3'd1;
                        k_nx     = '0;
                        state_nx = S_MAC;
                    end
                end
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule
